// File: rtl/vdma_pkg.sv
// Shared constants and FSM state encoding for the VDMA write sequencer slice.
package vdma_pkg;

  localparam int VDMA_ISIZE     = 24;
  localparam int VDMA_OSIZE     = 256;
  localparam int VDMA_BURST_LEN = 16;
  localparam int VDMA_ADDR_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_VS   = 2'd1,
    ST_WAIT_LINE = 2'd2,
    ST_LINE      = 2'd3
  } vdma_state_e;

endpackage

// File: rtl/vdma_cmd_slot.sv
// One-entry valid/ready command holding register; a load that arrives while the
// held command is still stalled is dropped and flagged in a sticky overflow bit.
module vdma_cmd_slot
  import vdma_pkg::*;
#(
  parameter int ADDR_W = VDMA_ADDR_W
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_len,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  output logic              overflow
);

  logic blocked_s;

  assign blocked_s = cmd_valid & ~cmd_ready;

  // Hold, replace or retire the single command entry; record drops.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_len   <= 8'd0;
      overflow  <= 1'b0;
    end else begin
      if (load && !blocked_s) begin
        cmd_valid <= 1'b1;
        cmd_addr  <= load_addr;
        cmd_len   <= load_len;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
      if (load && blocked_s) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vdma_wr_sequencer.sv
// Video DMA write sequencer: frames the pixel stream for an external packer and
// turns packed-word counts into burst write commands with line-pitch addressing.
module vdma_wr_sequencer
  import vdma_pkg::*;
#(
  parameter int ISIZE     = VDMA_ISIZE,
  parameter int OSIZE     = VDMA_OSIZE,
  parameter int BURST_LEN = VDMA_BURST_LEN,
  parameter int ADDR_W    = VDMA_ADDR_W
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              vs_i,
  input  logic              de_i,
  input  logic [ISIZE-1:0]  pdata_i,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [ADDR_W-1:0] line_stride,
  output logic              pk_wr_en,
  output logic [ISIZE-1:0]  pk_data,
  output logic              pk_align,
  output logic              pk_last,
  input  logic              pk_owr_en,
  input  logic              pk_olast,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  output logic              frame_done,
  output logic              busy,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] BYTES_PER_WORD = ADDR_W'(OSIZE / 8);
  localparam logic [8:0]        BURST_WORDS    = 9'(BURST_LEN);

  vdma_state_e       state_r, state_nxt_s;
  logic              vs_d1_r, de_d1_r, de_d2_r;
  logic [ISIZE-1:0]  pdata_d1_r;
  logic              frame_done_r;
  logic [8:0]        word_cnt_r, word_cnt_nxt_s, cnt_inc_s;
  logic [ADDR_W-1:0] line_addr_r, line_addr_nxt_s, cur_addr_r, cur_addr_nxt_s;
  logic [ADDR_W-1:0] line_next_s;
  logic              vs_rise_s, de_rise_s, in_frame_s, reload_s, end_frame_s;
  logic              burst_due_s;
  logic [7:0]        burst_len_s;

  assign vs_rise_s  = vs_i & ~vs_d1_r;
  assign de_rise_s  = de_i & ~de_d1_r;
  assign in_frame_s = (state_r == ST_LINE) || (state_r == ST_WAIT_LINE);

  // pk_last looks one pixel ahead at de_i so the flag lands on the final pixel.
  assign pk_wr_en   = in_frame_s & de_d1_r;
  assign pk_data    = pdata_d1_r;
  assign pk_align   = in_frame_s & de_d1_r & ~de_d2_r;
  assign pk_last    = in_frame_s & de_d1_r & ~de_i;
  assign busy       = (state_r != ST_IDLE);
  assign frame_done = frame_done_r;

  assign cnt_inc_s   = word_cnt_r + {8'd0, pk_owr_en};
  assign burst_due_s = (cnt_inc_s == BURST_WORDS) | (pk_olast & (cnt_inc_s != 9'd0));
  assign burst_len_s = 8'(cnt_inc_s - 9'd1);
  assign line_next_s = line_addr_r + line_stride;

  // Next-state logic; a frame sync inside a frame always closes it.
  always_comb begin
    state_nxt_s = state_r;
    reload_s    = 1'b0;
    end_frame_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable) state_nxt_s = ST_WAIT_VS;
        else        state_nxt_s = ST_IDLE;
      end
      ST_WAIT_VS: begin
        if (vs_rise_s) begin
          state_nxt_s = ST_WAIT_LINE;
          reload_s    = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT_VS;
        end
      end
      ST_WAIT_LINE: begin
        if (vs_rise_s) begin
          reload_s    = 1'b1;
          end_frame_s = 1'b1;
          state_nxt_s = enable ? ST_WAIT_LINE : ST_IDLE;
        end else if (de_rise_s) begin
          state_nxt_s = ST_LINE;
        end else begin
          state_nxt_s = ST_WAIT_LINE;
        end
      end
      ST_LINE: begin
        if (vs_rise_s) begin
          reload_s    = 1'b1;
          end_frame_s = 1'b1;
          state_nxt_s = enable ? ST_WAIT_LINE : ST_IDLE;
        end else if (pk_olast) begin
          state_nxt_s = ST_WAIT_LINE;
        end else begin
          state_nxt_s = ST_LINE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Address/count update; a line end overrides the burst advance of cur_addr.
  always_comb begin
    word_cnt_nxt_s  = word_cnt_r;
    cur_addr_nxt_s  = cur_addr_r;
    line_addr_nxt_s = line_addr_r;
    if (reload_s) begin
      word_cnt_nxt_s  = 9'd0;
      cur_addr_nxt_s  = frame_base;
      line_addr_nxt_s = frame_base;
    end else begin
      if (burst_due_s) begin
        word_cnt_nxt_s = 9'd0;
        cur_addr_nxt_s = cur_addr_r + (ADDR_W'(cnt_inc_s) * BYTES_PER_WORD);
      end else begin
        word_cnt_nxt_s = cnt_inc_s;
        cur_addr_nxt_s = cur_addr_r;
      end
      if (pk_olast) begin
        line_addr_nxt_s = line_next_s;
        cur_addr_nxt_s  = line_next_s;
      end else begin
        line_addr_nxt_s = line_addr_r;
      end
    end
  end

  // Sequential state: sync delays, FSM, frame pulse, addresses.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      vs_d1_r      <= 1'b0;
      de_d1_r      <= 1'b0;
      de_d2_r      <= 1'b0;
      pdata_d1_r   <= '0;
      frame_done_r <= 1'b0;
      word_cnt_r   <= 9'd0;
      line_addr_r  <= '0;
      cur_addr_r   <= '0;
    end else begin
      state_r      <= state_nxt_s;
      vs_d1_r      <= vs_i;
      de_d1_r      <= de_i;
      de_d2_r      <= de_d1_r;
      pdata_d1_r   <= pdata_i;
      frame_done_r <= end_frame_s;
      word_cnt_r   <= word_cnt_nxt_s;
      line_addr_r  <= line_addr_nxt_s;
      cur_addr_r   <= cur_addr_nxt_s;
    end
  end

  vdma_cmd_slot #(
    .ADDR_W (ADDR_W)
  ) u_cmd_slot (
    .clock     (clock),
    .rst_n     (rst_n),
    .load      (burst_due_s),
    .load_addr (cur_addr_r),
    .load_len  (burst_len_s),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_vdma_wr_sequencer.sv
// Scoreboard bench for vdma_wr_sequencer: stimulus pushes expected pixels and
// commands from a line-level address model; negedge monitors pop and compare.
module tb_vdma_wr_sequencer;

  localparam int BL  = 16;
  localparam int BPW = 32;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        enable, vs_i, de_i;
  logic [23:0] pdata_i;
  logic [31:0] frame_base, line_stride;
  logic        pk_wr_en, pk_align, pk_last;
  logic [23:0] pk_data;
  logic        pk_owr_en, pk_olast;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        frame_done, busy, overflow;

  int checks = 0;
  int errors = 0;
  int pix_seen = 0;
  logic [25:0] exp_pix_q[$];
  logic [39:0] exp_cmd_q[$];
  logic [31:0] m_line, m_stride;

  vdma_wr_sequencer dut (
    .clock(clock), .rst_n(rst_n), .enable(enable), .vs_i(vs_i), .de_i(de_i),
    .pdata_i(pdata_i), .frame_base(frame_base), .line_stride(line_stride),
    .pk_wr_en(pk_wr_en), .pk_data(pk_data), .pk_align(pk_align), .pk_last(pk_last),
    .pk_owr_en(pk_owr_en), .pk_olast(pk_olast), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .frame_done(frame_done), .busy(busy), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pixel and command monitors
  always @(negedge clock) begin
    if (rst_n) begin
      if (pk_wr_en) begin
        pix_seen++;
        if (exp_pix_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pixel_unexpected: got data 0x%0h with empty queue", pk_data);
        end else begin
          chk("pixel", 64'({pk_data, pk_align, pk_last}), 64'(exp_pix_q.pop_front()));
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected: got addr 0x%0h len %0d with empty queue", cmd_addr, cmd_len);
        end else begin
          chk("cmd", 64'({cmd_addr, cmd_len}), 64'(exp_cmd_q.pop_front()));
        end
      end
    end
  end

  // Reference model: a line of n words splits into bursts of at most BL words.
  task automatic model_line(input int n);
    for (int k = 0; k < n; k += BL) begin
      int c;
      logic [31:0] a;
      c = (n - k > BL) ? BL : n - k;
      a = m_line + 32'(k * BPW);
      exp_cmd_q.push_back({a, 8'(c - 1)});
    end
    m_line = m_line + m_stride;
  endtask

  task automatic drive_line(input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      if (i == drop_at) enable = 1'b0;
      de_i    = 1'b1;
      pdata_i = 24'($urandom);
      exp_pix_q.push_back({pdata_i, (i == 0), (i == n - 1)});
      tick();
    end
    de_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_words(input int n, input bit coinc, input bit do_olast);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      pk_owr_en = 1'b1;
      pk_olast  = do_olast && coinc && (i == n - 1);
      tick();
      pk_owr_en = 1'b0;
      pk_olast  = 1'b0;
    end
    if (do_olast && (!coinc || n == 0)) begin
      pk_olast = 1'b1;
      tick();
      pk_olast = 1'b0;
    end
    tick();
  endtask

  task automatic vs_pulse(input bit exp_done);
    vs_i = 1'b1;
    tick();
    chk("frame_done_pulse", 64'(frame_done), 64'(exp_done));
    vs_i = 1'b0;
    tick();
    chk("frame_done_clear", 64'(frame_done), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pk_wr_en"}, 64'(pk_wr_en), 64'd0);
    chk({tag, "_pk_align"}, 64'(pk_align), 64'd0);
    chk({tag, "_pk_last"}, 64'(pk_last), 64'd0);
    chk({tag, "_pk_data"}, 64'(pk_data), 64'd0);
    chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_cmd_addr"}, 64'(cmd_addr), 64'd0);
    chk({tag, "_cmd_len"}, 64'(cmd_len), 64'd0);
    chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; vs_i = 1'b0; de_i = 1'b0; pdata_i = 24'h5a5a5a;
    frame_base = 32'h0000_1000; line_stride = 32'h0000_2000;
    pk_owr_en = 1'b0; pk_olast = 1'b0; cmd_ready = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Pixel path gated while idle
    repeat (3) begin de_i = 1'b1; tick(); end
    de_i = 1'b0;
    repeat (3) tick();
    chk("gated_pix_count", 64'(pix_seen), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Line timing and bursts in the first frame
    enable = 1'b1;
    tick();
    chk("wait_vs_busy", 64'(busy), 64'd1);
    m_stride = line_stride;
    vs_pulse(1'b0);
    m_line = frame_base;
    drive_line(32, -1);
    chk("line_pix_count", 64'(pix_seen), 64'd32);
    exp_cmd_q.push_back({32'h0000_1000, 8'd15});
    exp_cmd_q.push_back({32'h0000_1200, 8'd15});
    exp_cmd_q.push_back({32'h0000_1400, 8'd7});
    m_line = m_line + m_stride;
    send_words(40, 1'b0, 1'b1);

    // Stride between two lines
    frame_base = 32'h0000_1000;
    line_stride = 32'h0000_2000;
    vs_pulse(1'b1);
    exp_cmd_q.push_back({32'h0000_1000, 8'd2});
    exp_cmd_q.push_back({32'h0000_3000, 8'd2});
    drive_line(3, -1);
    send_words(3, 1'b1, 1'b1);
    drive_line(3, -1);
    send_words(3, 1'b0, 1'b1);

    // Randomized frames against the line-level model
    for (int f = 0; f < 4; f++) begin
      frame_base  = (f == 0) ? 32'hFFFF_FF00 : $urandom;
      line_stride = $urandom;
      m_stride    = line_stride;
      vs_pulse(1'b1);
      m_line = frame_base;
      repeat ($urandom_range(1, 3)) begin
        int n;
        bit c;
        n = $urandom_range(0, 40);
        c = 1'($urandom_range(0, 1));
        drive_line($urandom_range(1, 12), -1);
        model_line(n);
        send_words(n, c, 1'b1);
      end
    end

    // Backpressure: hold first command, drop second, address still advances
    frame_base  = 32'h0000_8000;
    line_stride = 32'h0000_0100;
    vs_pulse(1'b1);
    cmd_ready = 1'b0;
    exp_cmd_q.push_back({32'h0000_8000, 8'd15});
    send_words(16, 1'b0, 1'b0);
    chk("bp_valid", 64'(cmd_valid), 64'd1);
    chk("bp_hold", 64'({cmd_addr, cmd_len}), 64'({32'h0000_8000, 8'd15}));
    chk("bp_no_overflow_yet", 64'(overflow), 64'd0);
    send_words(16, 1'b0, 1'b0);
    chk("bp_overflow", 64'(overflow), 64'd1);
    chk("bp_hold_after_drop", 64'({cmd_addr, cmd_len}), 64'({32'h0000_8000, 8'd15}));
    cmd_ready = 1'b1;
    tick();
    exp_cmd_q.push_back({32'h0000_8400, 8'd4});
    send_words(5, 1'b1, 1'b1);
    chk("bp_overflow_sticky", 64'(overflow), 64'd1);

    // Stop: enable drops mid-line, frame finishes at the next sync
    frame_base = 32'h0004_0000;
    line_stride = 32'h0000_0800;
    m_stride = line_stride;
    vs_pulse(1'b1);
    m_line = frame_base;
    drive_line(8, 4);
    model_line(5);
    send_words(5, 1'b1, 1'b1);
    chk("stop_still_busy", 64'(busy), 64'd1);
    vs_pulse(1'b1);
    chk("stop_idle", 64'(busy), 64'd0);

    // Reset mid-line with a stalled command pending
    enable = 1'b1;
    tick();
    vs_pulse(1'b0);
    drive_line(4, -1);
    cmd_ready = 1'b0;
    send_words(16, 1'b0, 1'b0);
    chk("rst_pre_valid", 64'(cmd_valid), 64'd1);
    chk("rst_pre_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    enable = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    repeat (5) tick();
    chk("post_rst_no_cmd", 64'(cmd_valid), 64'd0);
    chk("post_rst_overflow", 64'(overflow), 64'd0);

    chk("pix_queue_empty", 64'(exp_pix_q.size()), 64'd0);
    chk("cmd_queue_empty", 64'(exp_cmd_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vdma_wr_sequencer.md
VDMA_WR_SEQUENCER -- requirements
Module: vdma_wr_sequencer

Interface
REQ-001 Parameter ISIZE, default 24: pixel width in bits.
REQ-002 Parameter OSIZE, default 256: packed word width in bits; the byte increment per word is OSIZE/8.
REQ-003 Parameter BURST_LEN, default 16: maximum packed words per write command, range 1..256.
REQ-004 Parameter ADDR_W, default 32: address width.
REQ-005 Reset is rst_n, asynchronous, active-low; the clock is clock.
REQ-006 Ports, in the form name / direction / width / meaning:
- clock / in / 1 / clock.
- rst_n / in / 1 / reset.
- enable / in / 1 / run request.
- vs_i / in / 1 / frame sync; its rising edge starts a frame.
- de_i / in / 1 / pixel valid.
- pdata_i / in / ISIZE / pixel.
- frame_base / in / ADDR_W / frame start address.
- line_stride / in / ADDR_W / line pitch in bytes.
- pk_wr_en / out / 1 / packer write.
- pk_data / out / ISIZE / packer data.
- pk_align / out / 1 / first pixel of line.
- pk_last / out / 1 / last pixel of line.
- pk_owr_en / in / 1 / packer produced one word.
- pk_olast / in / 1 / packer flushed line end.
- cmd_valid / out / 1 / write command valid.
- cmd_ready / in / 1 / write command accepted.
- cmd_addr / out / ADDR_W / burst address.
- cmd_len / out / 8 / burst word count minus 1.
- frame_done / out / 1 / one-cycle pulse.
- busy / out / 1 / state is not IDLE.
- overflow / out / 1 / sticky: a command was dropped.

Function
REQ-007 The pixel path SHALL register once: pk_wr_en=de_d1, pk_data=pdata_d1, pk_align=de_d1&~de_d2, pk_last=de_d1&~de_i; latency is 1 cycle.
REQ-008 The pixel path SHALL be gated: pk_wr_en, pk_align and pk_last SHALL be 0 unless the state is LINE or WAIT_LINE.
REQ-009 The FSM SHALL have the states IDLE, WAIT_VS, WAIT_LINE and LINE.
- IDLE goes to WAIT_VS when enable=1.
- WAIT_VS goes to WAIT_LINE on a vs_i rise.
- WAIT_LINE goes to LINE on a de_i rise.
- LINE goes to WAIT_LINE on the cycle pk_olast=1.
REQ-010 On a vs_i rise in WAIT_VS, the block SHALL load line_addr and cur_addr from frame_base.
REQ-011 A vs_i rise in WAIT_LINE or LINE SHALL pulse frame_done the next cycle and reload line_addr and cur_addr from frame_base.
- If enable=0, the FSM goes to IDLE; otherwise it goes to WAIT_LINE.
REQ-012 Clearing enable SHALL NOT abort a frame; the FSM returns to IDLE only at the next vs_i rise.
REQ-013 word_cnt (9 bits) SHALL increment on each pk_owr_en.
REQ-014 A command SHALL issue when word_cnt reaches BURST_LEN, or when pk_olast=1 with word_cnt>0 (pk_olast counts its coincident pk_owr_en).
- It sets cmd_addr=cur_addr and cmd_len=word_cnt-1.
- It advances cur_addr by word_cnt*OSIZE/8 and clears word_cnt.
REQ-015 On pk_olast, the block SHALL add line_stride to line_addr and set cur_addr to the new line_addr, overriding REQ-014's advance.
REQ-016 cmd_valid SHALL stay high with cmd_addr and cmd_len stable until the cycle cmd_ready=1.
- A new command may load in the same cycle as acceptance.
REQ-017 If a command is due while cmd_valid=1 and cmd_ready=0, the new command SHALL be dropped, overflow SHALL set, and the address still advances.
- overflow clears only on reset.
REQ-018 Address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-019 Reset SHALL force the following:
- State IDLE.
- pk_wr_en, pk_align, pk_last, cmd_valid, frame_done, busy, overflow all 0.
- cmd_addr, cmd_len, pk_data, word_cnt, line_addr, cur_addr all 0.
- Sync delay registers 0.
REQ-020 Reset mid-burst SHALL discard any pending command without issuing it.

Structure
REQ-021 A shared package vdma_pkg SHALL hold the FSM state encoding and the default ISIZE/OSIZE/BURST_LEN/ADDR_W constants.
REQ-022 A single sub-module vdma_cmd_slot (a one-entry valid/ready holding register with drop detection) SHALL implement REQ-016 and REQ-017.
REQ-023 The packer SHALL be instantiated outside this block.

Verification
REQ-024 Line timing: enable=1, vs pulse, de high 32 cycles -> pk_align in cycle 1 of de_d1, pk_last on the 32nd pixel, 32 pk_wr_en.
REQ-025 Bursts: frame_base=0x1000, 40 pk_owr_en then pk_olast, cmd_ready=1 -> commands (0x1000,15), (0x1200,15), (0x1400,7).
REQ-026 Stride: line_stride=0x2000, two lines of 3 words each -> commands (0x1000,2) then (0x3000,2).
REQ-027 Backpressure: cmd_ready=0 across two due commands -> first command held stable, second dropped, overflow=1.
REQ-028 Stop: enable dropped mid-line -> line completes, frame_done pulses at the next vs rise, busy=0 the following cycle.
REQ-029 Reset: rst_n asserted during LINE with cmd_valid=1 -> all outputs 0 immediately, state IDLE.
